// File: rtl/mmcm_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : mmcm_lock_supervisor
// Purpose  : Drives MMCM RST, retries on lock timeout, and releases sys_rstn
//            only after synchronized LOCKED has been stable long enough.
// Revision : 1.0
// ============================================================================
module mmcm_lock_supervisor #(
   parameter int RST_PULSE     = 16,
   parameter int LOCK_TIMEOUT  = 125000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int SYNC_STAGES   = 2,
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic          clk_125mhz,
   input  logic          rstn_125mhz,
   input  logic          locked_async,
   input  logic          restart,
   output logic          mmcm_rst,
   output logic          sys_rstn,
   output logic          fail,
   output logic [RW-1:0] retry_cnt
);

   localparam int c_MAX_AB = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
   localparam int c_MAX_ALL = (c_MAX_AB > STABLE_CYCLES) ? c_MAX_AB : STABLE_CYCLES;
   localparam int CW = $clog2(c_MAX_ALL + 1);

   localparam logic [CW-1:0] c_RST_LAST     = CW'(RST_PULSE - 1);
   localparam logic [CW-1:0] c_TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] c_STABLE_LAST  = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] c_RETRY_MAX    = RW'(MAX_RETRIES);

   localparam logic [2:0] c_S_RST_MMCM  = 3'd0;
   localparam logic [2:0] c_S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] c_S_STABLE    = 3'd2;
   localparam logic [2:0] c_S_RUN       = 3'd3;
   localparam logic [2:0] c_S_FAIL      = 3'd4;

   logic [SYNC_STAGES-1:0] r_sync;
   logic [2:0]             r_state;
   logic [CW-1:0]          r_cnt;
   logic [RW-1:0]          r_retry;
   logic                   r_mmcm_rst;
   logic                   r_sys_rstn;
   logic                   r_fail;

   logic                   w_locked_s;
   logic [2:0]             w_next;
   logic [RW-1:0]          w_retry_next;
   logic                   w_timed;

   assign w_locked_s = r_sync[SYNC_STAGES-1];
   assign w_timed    = (r_state != c_S_RUN) && (r_state != c_S_FAIL);

   always_comb begin
      w_next       = r_state;
      w_retry_next = r_retry;
      case (r_state)
         c_S_RST_MMCM: begin
            if (r_cnt == c_RST_LAST) w_next = c_S_WAIT_LOCK;
         end
         c_S_WAIT_LOCK: begin
            // A lock seen on the timeout cycle takes priority over the retry.
            if (w_locked_s) begin
               w_next = c_S_STABLE;
            end else if (r_cnt == c_TIMEOUT_LAST) begin
               if (r_retry == c_RETRY_MAX) begin
                  w_next = c_S_FAIL;
               end else begin
                  w_next       = c_S_RST_MMCM;
                  w_retry_next = r_retry + RW'(1);
               end
            end
         end
         c_S_STABLE: begin
            if (!w_locked_s) begin
               w_next = c_S_WAIT_LOCK;
            end else if (r_cnt == c_STABLE_LAST) begin
               w_next       = c_S_RUN;
               w_retry_next = '0;
            end
         end
         c_S_RUN: begin
            if (!w_locked_s) w_next = c_S_RST_MMCM;
         end
         c_S_FAIL: begin
            if (restart) begin
               w_next       = c_S_RST_MMCM;
               w_retry_next = '0;
            end
         end
         default: begin
            w_next       = c_S_RST_MMCM;
            w_retry_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk_125mhz) begin
      if (!rstn_125mhz) begin
         r_sync     <= '0;
         r_state    <= c_S_RST_MMCM;
         r_cnt      <= '0;
         r_retry    <= '0;
         r_mmcm_rst <= 1'b1;
         r_sys_rstn <= 1'b0;
         r_fail     <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], locked_async};
         r_state <= w_next;
         r_retry <= w_retry_next;
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (w_timed) begin
            r_cnt <= r_cnt + CW'(1);
         end
         // Outputs follow the next state so they switch on the same edge as the FSM.
         r_mmcm_rst <= (w_next == c_S_RST_MMCM) || (w_next == c_S_FAIL);
         r_sys_rstn <= (w_next == c_S_RUN);
         r_fail     <= (w_next == c_S_FAIL);
      end
   end

   assign mmcm_rst  = r_mmcm_rst;
   assign sys_rstn  = r_sys_rstn;
   assign fail      = r_fail;
   assign retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmcm_lock_supervisor
// Purpose  : Directed self-checking bench for mmcm_lock_supervisor.
// Revision : 1.0
// ============================================================================
module tb_mmcm_lock_supervisor;

   logic       clk;
   logic       rstn;
   logic       locked;
   logic       restart;
   logic       mmcm_rst;
   logic       sys_rstn;
   logic       fail;
   logic [1:0] retry_cnt;

   int n_tests;
   int n_fail;

   mmcm_lock_supervisor #(
      .RST_PULSE    (4),
      .LOCK_TIMEOUT (50),
      .STABLE_CYCLES(8),
      .MAX_RETRIES  (2),
      .SYNC_STAGES  (2)
   ) u_dut (
      .clk_125mhz  (clk),
      .rstn_125mhz (rstn),
      .locked_async(locked),
      .restart     (restart),
      .mmcm_rst    (mmcm_rst),
      .sys_rstn    (sys_rstn),
      .fail        (fail),
      .retry_cnt   (retry_cnt)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(3);
      n_tests++; if (mmcm_rst !== 1'b1) begin n_fail++; $display("FAIL reset_mmcm_rst got=%b exp=1", mmcm_rst); end
      n_tests++; if (sys_rstn !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rstn got=%b exp=0", sys_rstn); end
      n_tests++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail got=%b exp=0", fail); end
      n_tests++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_retry got=%0d exp=0", retry_cnt); end
   endtask

   task automatic test_nominal();
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         n_tests++;
         if (mmcm_rst !== (i < 3)) begin n_fail++; $display("FAIL nom_pulse edge=%0d got=%b exp=%b", i, mmcm_rst, (i < 3)); end
      end
      step(9);
      locked = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         step(1);
         n_tests++;
         if (sys_rstn !== (i >= 11)) begin n_fail++; $display("FAIL nom_release edge=%0d got=%b exp=%b", i, sys_rstn, (i >= 11)); end
      end
      n_tests++; if (mmcm_rst !== 1'b0) begin n_fail++; $display("FAIL nom_mmcm_low got=%b exp=0", mmcm_rst); end
      n_tests++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL nom_retry got=%0d exp=0", retry_cnt); end
   endtask

   task automatic test_restart_in_run();
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      n_tests++; if (sys_rstn !== 1'b1) begin n_fail++; $display("FAIL run_restart_sys got=%b exp=1", sys_rstn); end
      n_tests++; if (mmcm_rst !== 1'b0) begin n_fail++; $display("FAIL run_restart_mmcm got=%b exp=0", mmcm_rst); end
      step(2);
      n_tests++; if (sys_rstn !== 1'b1) begin n_fail++; $display("FAIL run_restart_hold got=%b exp=1", sys_rstn); end
   endtask

   task automatic test_lock_loss_run();
      locked = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step(1);
         n_tests++;
         if (sys_rstn !== (i < 3)) begin n_fail++; $display("FAIL loss_sys edge=%0d got=%b exp=%b", i, sys_rstn, (i < 3)); end
         n_tests++;
         if (mmcm_rst !== (i >= 3)) begin n_fail++; $display("FAIL loss_mmcm edge=%0d got=%b exp=%b", i, mmcm_rst, (i >= 3)); end
      end
      for (int j = 1; j <= 4; j++) begin
         step(1);
         n_tests++;
         if (mmcm_rst !== (j < 4)) begin n_fail++; $display("FAIL loss_pulse j=%0d got=%b exp=%b", j, mmcm_rst, (j < 4)); end
      end
      n_tests++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL loss_retry got=%0d exp=0", retry_cnt); end
   endtask

   task automatic test_glitch_stable();
      locked = 1'b1;
      step(7);
      locked = 1'b0;
      step(3);
      locked = 1'b1;
      n_tests++; if (sys_rstn !== 1'b0) begin n_fail++; $display("FAIL glitch_sys got=%b exp=0", sys_rstn); end
      n_tests++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL glitch_retry got=%0d exp=0", retry_cnt); end
      n_tests++; if (mmcm_rst !== 1'b0) begin n_fail++; $display("FAIL glitch_mmcm got=%b exp=0", mmcm_rst); end
      step(10);
      n_tests++; if (sys_rstn !== 1'b0) begin n_fail++; $display("FAIL glitch_early got=%b exp=0", sys_rstn); end
      step(1);
      n_tests++; if (sys_rstn !== 1'b1) begin n_fail++; $display("FAIL glitch_release got=%b exp=1", sys_rstn); end
   endtask

   task automatic test_never_locks();
      logic       exp_m;
      logic [1:0] exp_r;
      rstn   = 1'b0;
      locked = 1'b0;
      step(2);
      rstn = 1'b1;
      for (int e = 0; e <= 170; e++) begin
         step(1);
         exp_m = (e <= 2) || (e >= 53 && e <= 56) || (e >= 107 && e <= 110) || (e >= 161);
         exp_r = (e >= 107) ? 2'd2 : (e >= 53) ? 2'd1 : 2'd0;
         n_tests++;
         if (mmcm_rst !== exp_m) begin n_fail++; $display("FAIL never_mmcm edge=%0d got=%b exp=%b", e, mmcm_rst, exp_m); end
         n_tests++;
         if (fail !== (e >= 161)) begin n_fail++; $display("FAIL never_fail edge=%0d got=%b exp=%b", e, fail, (e >= 161)); end
         n_tests++;
         if (retry_cnt !== exp_r) begin n_fail++; $display("FAIL never_retry edge=%0d got=%0d exp=%0d", e, retry_cnt, exp_r); end
      end
   endtask

   task automatic test_restart_from_fail();
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      n_tests++; if (fail !== 1'b0) begin n_fail++; $display("FAIL restart_fail got=%b exp=0", fail); end
      n_tests++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL restart_retry got=%0d exp=0", retry_cnt); end
      for (int j = 1; j <= 4; j++) begin
         step(1);
         n_tests++;
         if (mmcm_rst !== (j < 4)) begin n_fail++; $display("FAIL restart_pulse j=%0d got=%b exp=%b", j, mmcm_rst, (j < 4)); end
      end
      step(9);
      locked = 1'b1;
      step(10);
      n_tests++; if (sys_rstn !== 1'b0) begin n_fail++; $display("FAIL restart_early got=%b exp=0", sys_rstn); end
      step(1);
      n_tests++; if (sys_rstn !== 1'b1) begin n_fail++; $display("FAIL restart_release got=%b exp=1", sys_rstn); end
   endtask

   task automatic test_reset_mid();
      rstn   = 1'b0;
      locked = 1'b0;
      step(2);
      rstn = 1'b1;
      step(54 + 4 + 5);
      n_tests++; if (retry_cnt !== 2'd1) begin n_fail++; $display("FAIL mid_pre_retry got=%0d exp=1", retry_cnt); end
      n_tests++; if (mmcm_rst !== 1'b0) begin n_fail++; $display("FAIL mid_pre_mmcm got=%b exp=0", mmcm_rst); end
      rstn = 1'b0;
      step(1);
      n_tests++; if (mmcm_rst !== 1'b1) begin n_fail++; $display("FAIL mid_mmcm got=%b exp=1", mmcm_rst); end
      n_tests++; if (sys_rstn !== 1'b0) begin n_fail++; $display("FAIL mid_sys got=%b exp=0", sys_rstn); end
      n_tests++; if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_retry got=%0d exp=0", retry_cnt); end
      n_tests++; if (fail !== 1'b0) begin n_fail++; $display("FAIL mid_fail got=%b exp=0", fail); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rstn    = 1'b0;
      locked  = 1'b0;
      restart = 1'b0;
      test_reset();
      test_nominal();
      test_restart_in_run();
      test_lock_loss_run();
      test_glitch_stable();
      test_never_locks();
      test_restart_from_fail();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
